// File: rtl/lsu_defs.sv
// Shared definitions for the load/store unit: size codes, FSM states,
// default memory depth and the access legality rule.
package lsu_defs;

  localparam int DMEM_DEPTH = 256;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  // Misaligned, illegal-size or beyond-the-end accesses are rejected before
  // any memory strobe is raised.
  function automatic logic access_bad(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [31:0] depth);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts/extends load data from a word and
// merges store data into the addressed lane of an existing word.
module lsu_lane_align
  import lsu_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [4:0]  bit_off;

  assign bit_off   = {addr_lo, 3'b000};
  assign byte_lane = word[bit_off +: 8];
  assign half_lane = addr_lo[1] ? word[31:16] : word[15:0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    load_data  = word;
    store_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        store_word = word;
        store_word[bit_off +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        store_word = addr_lo[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: turns byte-addressed CPU accesses into single-word
// DMEM reads/writes, with read-modify-write for byte and half stores.
module lsu_mem_ctrl
  import lsu_defs::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              LSU_req,
  input  logic              LSU_we,
  input  logic [1:0]        LSU_size,
  input  logic              LSU_unsigned,
  input  logic [DATA_W-1:0] LSU_addr,
  input  logic [DATA_W-1:0] LSU_wdata,
  output logic              LSU_busy,
  output logic              LSU_done,
  output logic              LSU_err,
  output logic [DATA_W-1:0] LSU_rdata,
  output logic [DATA_W-1:0] DMEM_address,
  output logic [DATA_W-1:0] DMEM_data_in,
  output logic              DMEM_mem_write,
  output logic              DMEM_mem_read,
  input  logic [DATA_W-1:0] DMEM_data_out
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              in_read, in_write, req_bad;
  logic [DATA_W-1:0] align_word, load_data, store_word;

  // Strobes are gated by rst so a reset edge can never commit a write.
  assign in_read    = (state_q == S_READ)  && !rst;
  assign in_write   = (state_q == S_WRITE) && !rst;
  assign align_word = (state_q == S_READ) ? DMEM_data_out : old_q;
  assign req_bad    = access_bad(LSU_size, LSU_addr, 32'(DEPTH_WORDS));

  lsu_lane_align u_align (
    .word        (align_word),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (LSU_req) begin
          we_d    = LSU_we;
          size_d  = LSU_size;
          uns_d   = LSU_unsigned;
          addr_d  = LSU_addr;
          wdata_d = LSU_wdata;
          rdata_d = '0;
          if (req_bad) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (!LSU_we || LSU_size != SZ_WORD) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_READ: begin
        old_d = DMEM_data_out;
        if (we_q) begin
          state_d = S_WRITE;
        end else begin
          rdata_d = load_data;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every register
  // here is small control/data state, so all of it is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign LSU_busy       = (state_q != S_IDLE);
  assign LSU_done       = done_q;
  assign LSU_err        = err_q;
  assign LSU_rdata      = rdata_q;
  assign DMEM_mem_read  = in_read;
  assign DMEM_mem_write = in_write;
  assign DMEM_address   = (in_read || in_write) ? {2'b00, addr_q[DATA_W-1:2]} : '0;
  assign DMEM_data_in   = !in_write ? '0 : (size_q == SZ_WORD) ? wdata_q : store_word;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: a word-array DMEM, a transaction-level
// reference model and a per-cycle compare process.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        LSU_req = 1'b0;
  logic        LSU_we = 1'b0;
  logic [1:0]  LSU_size = 2'b00;
  logic        LSU_unsigned = 1'b0;
  logic [31:0] LSU_addr = '0;
  logic [31:0] LSU_wdata = '0;
  logic        LSU_busy, LSU_done, LSU_err;
  logic [31:0] LSU_rdata, DMEM_address, DMEM_data_in, DMEM_data_out;
  logic        DMEM_mem_write, DMEM_mem_read;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .LSU_req(LSU_req), .LSU_we(LSU_we), .LSU_size(LSU_size),
    .LSU_unsigned(LSU_unsigned), .LSU_addr(LSU_addr), .LSU_wdata(LSU_wdata),
    .LSU_busy(LSU_busy), .LSU_done(LSU_done), .LSU_err(LSU_err), .LSU_rdata(LSU_rdata),
    .DMEM_address(DMEM_address), .DMEM_data_in(DMEM_data_in),
    .DMEM_mem_write(DMEM_mem_write), .DMEM_mem_read(DMEM_mem_read),
    .DMEM_data_out(DMEM_data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'h8899AABB;
    if (i == 2) return 32'h13572468;
    return (32'(i) * 32'h01000193) ^ 32'hC3C30000;
  endfunction

  // DMEM: combinational read (0 when not enabled), write commits at posedge.
  logic [31:0] mem [0:255];
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (DMEM_mem_write) begin
      mem[DMEM_address[7:0]] <= DMEM_data_in;
    end
  end
  assign DMEM_data_out = DMEM_mem_read ? mem[DMEM_address[7:0]] : 32'h0;

  // Reference model state: expected memory plus the timeline of the current op.
  logic [31:0] ref_mem [0:255];
  int          acc_cyc = -1, done_cyc = -1, rd_cyc = -1, wr_cyc = -1;
  logic [31:0] exp_idx = '0, exp_din = '0, exp_final = '0, exp_prev = '0;
  logic        exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("rst_mem_write", DMEM_mem_write, 1'b0);
      check("rst_mem_read", DMEM_mem_read, 1'b0);
    end else begin
      check("busy", LSU_busy, (cyc >= acc_cyc) && (cyc <= done_cyc));
      check("done", LSU_done, cyc == done_cyc);
      if (cyc == done_cyc) check("err", LSU_err, exp_err);
      check("rdata", LSU_rdata, (cyc < acc_cyc) ? exp_prev : (cyc < done_cyc) ? 32'h0 : exp_final);
      check("mem_read", DMEM_mem_read, cyc == rd_cyc);
      check("mem_write", DMEM_mem_write, cyc == wr_cyc);
      check("address", DMEM_address, (cyc == rd_cyc || cyc == wr_cyc) ? exp_idx : 32'h0);
      check("data_in", DMEM_data_in, (cyc == wr_cyc) ? exp_din : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise a request now; the next posedge is the accept edge. The model
  // derives latency, strobe cycles and results from the access rules.
  task automatic start_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    logic        bad;
    logic [31:0] old, sh, mask, val;
    int          off, lat, a;
    off  = int'(addr[1:0]);
    bad  = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd256);
    old  = bad ? 32'h0 : ref_mem[addr[9:2]];
    sh   = old >> (8 * off);
    case (size)
      2'b00:   val = uns ? (sh & 32'hFF)   : 32'($signed(sh[7:0]));
      2'b01:   val = uns ? (sh & 32'hFFFF) : 32'($signed(sh[15:0]));
      default: val = old;
    endcase
    mask = (size == 2'b00) ? (32'hFF << (8 * off)) :
           (size == 2'b01) ? (32'hFFFF << (8 * off)) : 32'hFFFFFFFF;
    lat  = bad ? 1 : (!we || size == 2'b10) ? 2 : 3;
    a    = cyc + 1;
    exp_prev  = exp_final;
    exp_final = (!bad && !we) ? val : 32'h0;
    exp_err   = bad;
    exp_idx   = addr >> 2;
    exp_din   = (old & ~mask) | ((wdata << (8 * off)) & mask);
    acc_cyc   = a;
    done_cyc  = a + lat - 1;
    rd_cyc    = (!bad && (!we || size != 2'b10)) ? a : -1;
    wr_cyc    = (!bad && we) ? done_cyc - 1 : -1;
    LSU_req = 1'b1; LSU_we = we; LSU_size = size; LSU_unsigned = uns;
    LSU_addr = addr; LSU_wdata = wdata;
  endtask

  task automatic wait_done(input logic release_req);
    int k = 0;
    while (!LSU_done && k < 12) begin
      step();
      k++;
    end
    check("done_seen", LSU_done, 1'b1);
    if (LSU_done && wr_cyc >= 0) ref_mem[exp_idx[7:0]] = exp_din;
    if (release_req) LSU_req = 1'b0;
  endtask

  task automatic op(input string name, input logic we, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] lit_rdata, input logic lit_err);
    start_op(we, size, uns, addr, wdata);
    wait_done(1'b1);
    check({name, "_rdata"}, LSU_rdata, lit_rdata);
    check({name, "_err"}, LSU_err, lit_err);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    step();
    preload = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    op("lb_5",   1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 32'hFFFFFFAA, 1'b0);
    op("lbu_5",  1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 32'h000000AA, 1'b0);
    op("lh_6",   1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'hFFFF8899, 1'b0);
    op("lhu_6",  1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'h00008899, 1'b0);
    op("lw_4",   1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h8899AABB, 1'b0);
    op("sh_6",   1'b1, 2'b01, 1'b0, 32'h6, 32'h00001234, 32'h0, 1'b0);
    op("lw_4b",  1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h1234AABB, 1'b0);
    op("lw_mis", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1);
    op("sh_mis", 1'b1, 2'b01, 1'b0, 32'h1, 32'hFFFF, 32'h0, 1'b1);
    op("lw_oor", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    op("sz_ill", 1'b0, 2'b11, 1'b0, 32'h4, 32'h0, 32'h0, 1'b1);
    op("lw_4c",  1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h1234AABB, 1'b0);
    op("sb_b",   1'b1, 2'b00, 1'b0, 32'hB, 32'h000000CC, 32'h0, 1'b0);
    op("lw_8",   1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hCC572468, 1'b0);
    op("lh_fc",  1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0, init_word(255) >> 16 | ((init_word(255) >> 31) != 0 ? 32'hFFFF0000 : 32'h0), 1'b0);

    // SW aborted by reset during its write cycle.
    start_op(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
    step();
    rst = 1'b1;
    LSU_req = 1'b0;
    acc_cyc = -1; done_cyc = -1; rd_cyc = -1; wr_cyc = -1;
    exp_final = 32'h0; exp_prev = 32'h0;
    step();
    rst = 1'b0;
    step();
    step();
    op("lw_8_after_rst", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hCC572468, 1'b0);

    // Extra request pulse while the LB is in its read cycle.
    start_op(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
    step();
    LSU_req = 1'b0;
    #2 LSU_req = 1'b1;
    step();
    LSU_req = 1'b0;
    wait_done(1'b1);
    check("pulse_rdata", LSU_rdata, 32'hFFFFFFAA);
    repeat (4) step();

    // Held request: the second accept only happens from IDLE.
    start_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    wait_done(1'b0);
    step();
    start_op(1'b0, 2'b00, 1'b1, 32'h7, 32'h0);
    wait_done(1'b1);
    check("held_rdata", LSU_rdata, 32'h00000012);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
